// File: rtl/sad_best_match.sv
// Tracks the minimum SAD over one search window and reports the winning address.
// Optional SAD_EARLY_EXIT_EN: a zero-SAD candidate ends the search immediately.
module sad_best_match #(
  parameter int NUM_CAND = 64,
  parameter int SAD_W    = 12,
  parameter int ADDR_W   = 8,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [SAD_W+ADDR_W-1:0] in_data,
  output logic                    busy,
  output logic                    done,
  output logic [SAD_W-1:0]        best_sad,
  output logic [ADDR_W-1:0]       best_addr,
  output logic [CNT_W-1:0]        cand_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CAND - 1);

  // Strictly-less keeps the earliest candidate on ties.
  function automatic logic beats(input logic [SAD_W-1:0] cand, input logic [SAD_W-1:0] cur);
    return cand < cur;
  endfunction

  logic [1:0]        state;
  logic [SAD_W-1:0]  run_sad;
  logic [ADDR_W-1:0] run_addr;

  logic [SAD_W-1:0]  smp_sad;
  logic [ADDR_W-1:0] smp_addr;
  logic              accept;
  logic              is_last;
  logic [SAD_W-1:0]  nxt_sad;
  logic [ADDR_W-1:0] nxt_addr;

  assign smp_sad  = in_data[SAD_W+ADDR_W-1:ADDR_W];
  assign smp_addr = in_data[ADDR_W-1:0];
  assign accept   = (state == SEARCH) && in_valid && !start;
  assign busy     = (state == SEARCH);

`ifdef SAD_EARLY_EXIT_EN
  assign is_last = (cand_cnt == LAST_CNT) || (smp_sad == '0);
`else
  assign is_last = (cand_cnt == LAST_CNT);
`endif

  always_comb begin
    nxt_sad  = run_sad;
    nxt_addr = run_addr;
    if (beats(smp_sad, run_sad)) begin
      nxt_sad  = smp_sad;
      nxt_addr = smp_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      run_sad   <= '1;
      run_addr  <= '0;
      cand_cnt  <= '0;
      best_sad  <= '0;
      best_addr <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // Restart from any state; the sample in this cycle is dropped.
        state    <= SEARCH;
        run_sad  <= '1;
        run_addr <= '0;
        cand_cnt <= '0;
      end else if (accept) begin
        cand_cnt <= cand_cnt + 1'b1;
        run_sad  <= nxt_sad;
        run_addr <= nxt_addr;
        if (is_last) begin
          best_sad  <= nxt_sad;
          best_addr <= nxt_addr;
          done      <= 1'b1;
          state     <= DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_sad_best_match.sv
// Scoreboard bench for sad_best_match with a 4-candidate window.
module tb_sad_best_match;

  localparam int NC = 4;
`ifdef SAD_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [19:0] in_data;
  logic        busy;
  logic        done;
  logic [11:0] best_sad;
  logic [7:0]  best_addr;
  logic [7:0]  cand_cnt;

  sad_best_match #(.NUM_CAND(NC), .SAD_W(12), .ADDR_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .busy(busy), .done(done), .best_sad(best_sad), .best_addr(best_addr), .cand_cnt(cand_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [27:0] sb_q[$];
  bit          m_srch = 1'b0;
  int          m_cnt = 0;
  logic [11:0] m_sad = '1;
  logic [7:0]  m_addr = '0;
  logic [11:0] ex_sad = '0;
  logic [7:0]  ex_addr = '0;
  logic [7:0]  ex_cnt = '0;

  task automatic drive(input logic v, input logic [11:0] s, input logic [7:0] a, input logic st);
    start    = st;
    in_valid = v;
    in_data  = {s, a};
    if (st) begin
      m_srch = 1'b1; m_cnt = 0; m_sad = '1; m_addr = '0;
    end else if (v && m_srch) begin
      if (s < m_sad) begin m_sad = s; m_addr = a; end
      m_cnt++;
      if (m_cnt == NC || (EE && s == 12'd0)) begin
        ex_sad = m_sad; ex_addr = m_addr; ex_cnt = 8'(m_cnt);
        sb_q.push_back({m_sad, m_addr, 8'(m_cnt)});
        m_srch = 1'b0;
      end
    end
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 12'd0, 8'd0, 1'b0);
  endtask

  // Result monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        logic [27:0] e;
        e = sb_q.pop_front();
        check("sb_best_sad", {20'd0, best_sad}, {20'd0, e[27:16]});
        check("sb_best_addr", {24'd0, best_addr}, {24'd0, e[15:8]});
        check("sb_cand_cnt", {24'd0, cand_cnt}, {24'd0, e[7:0]});
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_best_sad", best_sad, 0);
    check("rst_best_addr", best_addr, 0);
    check("rst_cand_cnt", cand_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // in_valid while idle is ignored
    drive(1'b1, 12'h00A, 8'h05, 1'b0);
    check("idle_busy", busy, 0);
    check("idle_cnt", cand_cnt, 0);
    check("idle_sad", best_sad, 0);

    // Basic search
    drive(1'b0, 12'd0, 8'd0, 1'b1);
    check("start_busy", busy, 1);
    drive(1'b1, 12'd300, 8'h2A, 1'b0);
    drive(1'b1, 12'd120, 8'h2B, 1'b0);
    drive(1'b1, 12'd450, 8'h2C, 1'b0);
    check("basic_not_done", done, 0);
    drive(1'b1, 12'd200, 8'h2D, 1'b0);
    check("basic_done", done, 1);
    check("basic_busy", busy, 0);
    check("basic_sad", best_sad, 120);
    check("basic_addr", best_addr, 8'h2B);
    check("basic_cnt", cand_cnt, 4);
    drive(1'b1, 12'd1, 8'h77, 1'b0);
    check("basic_done_low", done, 0);
    check("hold_sad", best_sad, ex_sad);
    check("hold_addr", best_addr, ex_addr);
    check("hold_cnt", cand_cnt, ex_cnt);

    // Reset mid-search clears everything at once
    drive(1'b0, 12'd0, 8'd0, 1'b1);
    drive(1'b1, 12'd7, 8'h01, 1'b0);
    #2 rst_n = 1'b0;
    m_srch = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_cnt", cand_cnt, 0);
    check("arst_sad", best_sad, 0);
    check("arst_addr", best_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Tie: earliest wins
    drive(1'b0, 12'd0, 8'd0, 1'b1);
    drive(1'b1, 12'd50, 8'h10, 1'b0);
    drive(1'b1, 12'd50, 8'h11, 1'b0);
    drive(1'b1, 12'd80, 8'h12, 1'b0);
    drive(1'b1, 12'd50, 8'h13, 1'b0);
    check("tie_done", done, 1);
    check("tie_addr", best_addr, 8'h10);
    idle(1);

    // Gapped valid 1,0,0,1,1,0,1
    drive(1'b0, 12'd0, 8'd0, 1'b1);
    drive(1'b1, 12'd70, 8'h30, 1'b0);
    idle(2);
    drive(1'b1, 12'd40, 8'h31, 1'b0);
    drive(1'b1, 12'd90, 8'h32, 1'b0);
    idle(1);
    check("gap_not_done", done, 0);
    drive(1'b1, 12'd40, 8'h33, 1'b0);
    check("gap_done", done, 1);
    check("gap_sad", best_sad, 40);
    check("gap_addr", best_addr, 8'h31);
    idle(1);

    // Restart after 2 samples
    drive(1'b0, 12'd0, 8'd0, 1'b1);
    drive(1'b1, 12'd10, 8'h40, 1'b0);
    drive(1'b1, 12'd20, 8'h41, 1'b0);
    drive(1'b0, 12'd0, 8'd0, 1'b1);
    check("restart_cnt", cand_cnt, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, 12'(90 + i), 8'(8'h50 + i), 1'b0);
    check("restart_done", done, 1);
    check("restart_sad", best_sad, 90);
    check("restart_addr", best_addr, 8'h50);
    idle(1);

    // start together with the would-be final sample: sample discarded
    drive(1'b0, 12'd0, 8'd0, 1'b1);
    drive(1'b1, 12'd60, 8'h60, 1'b0);
    drive(1'b1, 12'd61, 8'h61, 1'b0);
    drive(1'b1, 12'd62, 8'h62, 1'b0);
    drive(1'b1, 12'd5, 8'h63, 1'b1);
    check("collide_no_done", done, 0);
    check("collide_cnt", cand_cnt, 0);
    check("collide_busy", busy, 1);
    drive(1'b1, 12'd33, 8'h70, 1'b0);
    drive(1'b1, 12'd22, 8'h71, 1'b0);
    drive(1'b1, 12'd44, 8'h72, 1'b0);
    drive(1'b1, 12'd22, 8'h73, 1'b0);
    check("collide_sad", best_sad, 22);
    check("collide_addr", best_addr, 8'h71);
    idle(1);

    // Zero SAD as the second sample
    drive(1'b0, 12'd0, 8'd0, 1'b1);
    drive(1'b1, 12'd100, 8'h80, 1'b0);
    drive(1'b1, 12'd0, 8'h81, 1'b0);
    check("zero_done_early", done, EE ? 1 : 0);
    drive(1'b1, 12'd50, 8'h82, 1'b0);
    drive(1'b1, 12'd60, 8'h83, 1'b0);
    check("zero_done_full", done, EE ? 0 : 1);
    check("zero_sad", best_sad, 0);
    check("zero_addr", best_addr, 8'h81);
    check("zero_cnt", cand_cnt, EE ? 2 : 4);
    idle(2);

    check("sb_pending", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
